// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D cache RAM-port arbiter.
// Holds the grant state encoding and the round-robin pick function.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } arb_state_t;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // On a tie the port that did not own the RAM last goes first.
  function automatic arb_state_t arb_pick(input logic [1:0] active, input logic last_owner);
    arb_state_t pick;
    case (active)
      2'b01:   pick = S_OWN0;
      2'b10:   pick = S_OWN1;
      2'b11:   pick = last_owner ? S_OWN0 : S_OWN1;
      default: pick = S_IDLE;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side request bundle plus the non-tristate RAM-side signals.
// The arbiter uses the slave modport; the caches/RAM side uses master.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req_ce;
  logic [1:0]        req_rw;
  logic [1:0]        req_lock;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_wdata0;
  logic [DATA_W-1:0] req_wdata1;
  logic [DATA_W-1:0] req_rdata;
  logic [1:0]        req_ack;
  logic [1:0]        req_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ce;
  logic              mem_rw;
  logic              mem_ack;
  logic              timeout_o;

  modport slave (
    input  req_ce, req_rw, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_ack,
    output req_rdata, req_ack, req_gnt, mem_addr, mem_ce, mem_rw, timeout_o
  );

  modport master (
    output req_ce, req_rw, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_ack,
    input  req_rdata, req_ack, req_gnt, mem_addr, mem_ce, mem_rw, timeout_o
  );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Ack watchdog: counts stalled cycles of the current tenure and raises a
// one-cycle forced ack when the RAM has been silent for TIMEOUT cycles.
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mem_ce_i,
  input  logic mem_ack_i,
  input  logic gnt_change_i,
  output logic forced_ack_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign forced_ack_o = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
      localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             expire_q, expire_d;
      logic             stall_s;

      assign stall_s = mem_ce_i & ~mem_ack_i;

      // The expiry cycle itself is not counted, so expiries repeat every TIMEOUT+1 cycles.
      always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (gnt_change_i || !stall_s || expire_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          expire_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Counter and pending-expiry registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q    <= '0;
          expire_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          expire_q <= expire_d;
        end
      end

      // A real ack arriving in the expiry cycle takes precedence.
      assign forced_ack_o = expire_q & stall_s;
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single RAM port shared by the I-side (port 0) and
// D-side (port 1) L1 caches; grants whole tenures, with an ack watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_arb_if.slave          bus,
  inout  wire  [DATA_W-1:0] mem_data
);

  arb_state_t        state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [1:0]        active_s;
  logic [1:0]        gnt_s;
  logic              mem_ce_s, mem_rw_s, drive_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              gnt_change_s, forced_ack_s;

  assign active_s = bus.req_ce | bus.req_lock;

  // Grant state, tie-break history and idle address hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      mem_addr_q   <= mem_addr_s;
    end
  end

  // An owner keeps the grant while ce or lock is high; otherwise re-arbitrate in the same edge.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      S_OWN0: begin
        if (active_s[PORT_I]) state_d = S_OWN0;
        else                  state_d = arb_pick(active_s, last_owner_q);
      end
      S_OWN1: begin
        if (active_s[PORT_D]) state_d = S_OWN1;
        else                  state_d = arb_pick(active_s, last_owner_q);
      end
      default: state_d = arb_pick(active_s, last_owner_q);
    endcase
    case (state_d)
      S_OWN0:  last_owner_d = 1'b0;
      S_OWN1:  last_owner_d = 1'b1;
      default: last_owner_d = last_owner_q;
    endcase
  end

  // RAM side follows the owner combinationally; idle parks it as a read with the last address.
  always_comb begin
    mem_ce_s   = 1'b0;
    mem_rw_s   = 1'b1;
    mem_addr_s = mem_addr_q;
    wdata_s    = bus.req_wdata0;
    case (state_q)
      S_OWN0: begin
        mem_ce_s   = bus.req_ce[PORT_I];
        mem_rw_s   = bus.req_rw[PORT_I];
        mem_addr_s = bus.req_addr0;
        wdata_s    = bus.req_wdata0;
      end
      S_OWN1: begin
        mem_ce_s   = bus.req_ce[PORT_D];
        mem_rw_s   = bus.req_rw[PORT_D];
        mem_addr_s = bus.req_addr1;
        wdata_s    = bus.req_wdata1;
      end
      default: begin
        mem_ce_s   = 1'b0;
        mem_rw_s   = 1'b1;
        mem_addr_s = mem_addr_q;
      end
    endcase
  end

  assign gnt_s        = {state_q == S_OWN1, state_q == S_OWN0};
  assign gnt_change_s = (state_d != state_q);
  assign drive_s      = mem_ce_s & ~mem_rw_s;

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_ce_i    (mem_ce_s),
    .mem_ack_i   (bus.mem_ack),
    .gnt_change_i(gnt_change_s),
    .forced_ack_o(forced_ack_s)
  );

  assign mem_data      = drive_s ? wdata_s : {DATA_W{1'bz}};
  assign bus.mem_ce    = mem_ce_s;
  assign bus.mem_rw    = mem_rw_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.req_gnt   = gnt_s;
  // gnt_s is one-hot, so at most one port is ever acked.
  assign bus.req_ack   = gnt_s & {2{mem_ce_s & (bus.mem_ack | forced_ack_s)}};
  assign bus.req_rdata = forced_ack_s ? ERR_DATA : mem_data;
  assign bus.timeout_o = forced_ack_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, tie fairness, single read, burst
// lock, write routing, watchdog expiry and asynchronous reset mid-burst.
module tb_mem_port_arbiter;

  localparam logic [31:0] PROBE = 32'h5A5A_5A5A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tb_oe;
  logic [31:0] tb_val;
  wire  [31:0] mem_data;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .mem_data(mem_data)
  );

  assign mem_data = tb_oe ? tb_val : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req_ce     = 2'b00;
    bus.req_rw     = 2'b11;
    bus.req_lock   = 2'b00;
    bus.req_addr0  = 32'h0;
    bus.req_addr1  = 32'h0;
    bus.req_wdata0 = 32'h0;
    bus.req_wdata1 = 32'h0;
    bus.mem_ack    = 1'b0;
    tb_oe          = 1'b1;
    tb_val         = PROBE;
    #3;
    chk("rst_gnt", bus.req_gnt, 2'b00);
    chk("rst_ack", bus.req_ack, 2'b00);
    chk("rst_ce", bus.mem_ce, 1'b0);
    chk("rst_rw", bus.mem_rw, 1'b1);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_tmo", bus.timeout_o, 1'b0);
    chk("rst_data_z", mem_data, PROBE);
    tick();
    tick();
    reset_n = 1'b1;
    tb_oe   = 1'b0;

    // Tie from reset: port 0 first, port 1 waits, handover without idle
    bus.req_ce = 2'b11; bus.req_rw = 2'b11; bus.req_addr0 = 32'h80; bus.req_addr1 = 32'h90;
    #1 chk("tie_lat", bus.req_gnt, 2'b00);
    tick();
    bus.mem_ack = 1'b1; tb_oe = 1'b1; tb_val = 32'h1111;
    #1 chk("tie_gnt0", bus.req_gnt, 2'b01);
    chk("tie_addr0", bus.mem_addr, 32'h80);
    chk("tie_ack0", bus.req_ack, 2'b01);
    chk("tie_rd0", bus.req_rdata, 32'h1111);
    tick();
    bus.req_ce = 2'b10; tb_oe = 1'b0;
    #1 chk("ce0_low_gnt", bus.req_gnt, 2'b01);
    chk("ce0_low_ack", bus.req_ack, 2'b00);
    tick();
    tb_oe = 1'b1; tb_val = 32'h2222;
    #1 chk("tie_gnt1", bus.req_gnt, 2'b10);
    chk("tie_addr1", bus.mem_addr, 32'h90);
    chk("tie_ack1", bus.req_ack, 2'b10);
    chk("tie_rd1", bus.req_rdata, 32'h2222);
    tick();
    bus.req_ce = 2'b00; bus.mem_ack = 1'b0; tb_oe = 1'b0;
    #1 chk("tie_drop_ack", bus.req_ack, 2'b00);
    tick();
    bus.mem_ack = 1'b1;
    #1 chk("idle_gnt", bus.req_gnt, 2'b00);
    chk("idle_ack", bus.req_ack, 2'b00);
    chk("idle_addr_hold", bus.mem_addr, 32'h90);
    bus.mem_ack = 1'b0;

    // Single read on port 0, RAM acks two cycles after the request
    bus.req_ce = 2'b01; bus.req_rw = 2'b01; bus.req_addr0 = 32'h40;
    #1 chk("rd_lat", bus.req_gnt, 2'b00);
    tick();
    #1 chk("rd_gnt", bus.req_gnt, 2'b01);
    chk("rd_addr", bus.mem_addr, 32'h40);
    chk("rd_rw", bus.mem_rw, 1'b1);
    chk("rd_wait_ack", bus.req_ack, 2'b00);
    tick();
    bus.mem_ack = 1'b1; tb_oe = 1'b1; tb_val = 32'h1234;
    #1 chk("rd_ack", bus.req_ack, 2'b01);
    chk("rd_data", bus.req_rdata, 32'h1234);
    tick();
    bus.req_ce = 2'b00; bus.mem_ack = 1'b0; tb_oe = 1'b0;
    #1 chk("rd_ack_pulse", bus.req_ack, 2'b00);
    tick();
    #1 chk("rd_idle", bus.req_gnt, 2'b00);
    chk("rd_idle_addr", bus.mem_addr, 32'h40);

    // Second tie with last_owner=0: port 1 first
    bus.req_ce = 2'b11; bus.req_rw = 2'b11; bus.req_addr0 = 32'h84; bus.req_addr1 = 32'h94;
    tick();
    bus.mem_ack = 1'b1; tb_oe = 1'b1; tb_val = 32'h3333;
    #1 chk("tie2_gnt1", bus.req_gnt, 2'b10);
    chk("tie2_addr1", bus.mem_addr, 32'h94);
    chk("tie2_ack1", bus.req_ack, 2'b10);
    tick();
    bus.req_ce = 2'b01; bus.mem_ack = 1'b0; tb_oe = 1'b0;
    #1 chk("tie2_loser_wait", bus.req_ack, 2'b00);
    tick();
    bus.mem_ack = 1'b1; tb_oe = 1'b1; tb_val = 32'h4444;
    #1 chk("tie2_gnt0", bus.req_gnt, 2'b01);
    chk("tie2_ack0", bus.req_ack, 2'b01);
    chk("tie2_rd0", bus.req_rdata, 32'h4444);
    tick();
    bus.req_ce = 2'b00; bus.mem_ack = 1'b0; tb_oe = 1'b0;
    tick();

    // Locked 8-word burst on port 1 with ce dips while port 0 keeps requesting
    bus.req_ce = 2'b11; bus.req_lock = 2'b10; bus.req_rw = 2'b11;
    bus.req_addr0 = 32'hA0; bus.req_addr1 = 32'h100;
    #1 chk("bst_lat", bus.req_gnt, 2'b00);
    for (int w = 0; w < 8; w++) begin
      tick();
      bus.req_ce[1] = 1'b1; bus.req_addr1 = 32'h100 + 32'(4 * w);
      bus.mem_ack = 1'b1; tb_oe = 1'b1; tb_val = 32'h1000 + 32'(w);
      #1 chk("bst_gnt", bus.req_gnt, 2'b10);
      chk("bst_addr", bus.mem_addr, 32'h100 + 32'(4 * w));
      chk("bst_ack", bus.req_ack, 2'b10);
      chk("bst_rd", bus.req_rdata, 32'h1000 + 32'(w));
      tick();
      bus.req_ce[1] = 1'b0; bus.mem_ack = 1'b0; tb_oe = 1'b0;
      if (w == 7) bus.req_lock = 2'b00;
      #1 chk("dip_gnt", bus.req_gnt, 2'b10);
      chk("dip_ce", bus.mem_ce, 1'b0);
      chk("dip_ack", bus.req_ack, 2'b00);
    end
    tick();
    bus.mem_ack = 1'b1; tb_oe = 1'b1; tb_val = 32'h5555;
    #1 chk("bst_handover", bus.req_gnt, 2'b01);
    chk("bst_p0_addr", bus.mem_addr, 32'hA0);
    chk("bst_p0_ack", bus.req_ack, 2'b01);
    chk("bst_p0_rd", bus.req_rdata, 32'h5555);
    tick();
    bus.req_ce = 2'b00; bus.mem_ack = 1'b0; tb_oe = 1'b0;
    tick();

    // Port 1 write while port 0 read waits, then port 0 read with silent RAM
    bus.req_ce = 2'b11; bus.req_rw = 2'b01; bus.req_addr0 = 32'hB0;
    bus.req_addr1 = 32'h20; bus.req_wdata1 = 32'hCAFE_F00D;
    tick();
    #1 chk("wr_gnt", bus.req_gnt, 2'b10);
    chk("wr_rw", bus.mem_rw, 1'b0);
    chk("wr_ce", bus.mem_ce, 1'b1);
    chk("wr_data", mem_data, 32'hCAFE_F00D);
    chk("wr_wait_ack", bus.req_ack, 2'b00);
    tick();
    bus.mem_ack = 1'b1;
    #1 chk("wr_ack", bus.req_ack, 2'b10);
    tick();
    bus.req_ce = 2'b01; bus.mem_ack = 1'b0; tb_oe = 1'b1; tb_val = PROBE;
    #1 chk("wr_data_z", mem_data, PROBE);
    chk("wr_p0_noack", bus.req_ack, 2'b00);
    tb_oe = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 14) begin
        bus.mem_ack = 1'b1; tb_oe = 1'b1; tb_val = 32'h7777;
      end
      #1 chk("wd_gnt", bus.req_gnt, 2'b01);
      chk("wd_ack", bus.req_ack, (c == 4 || c == 9 || c == 14) ? 2'b01 : 2'b00);
      chk("wd_tmo", bus.timeout_o, (c == 4 || c == 9) ? 1'b1 : 1'b0);
      if (c == 4 || c == 9) chk("wd_err_data", bus.req_rdata, 32'hDEAD_BEEF);
      if (c == 14) chk("wd_real_wins", bus.req_rdata, 32'h7777);
    end
    tick();
    bus.req_ce = 2'b00; bus.mem_ack = 1'b0; tb_oe = 1'b0;
    tick();

    // Locked write burst on port 1, reset asserted during word 3
    bus.req_ce = 2'b10; bus.req_lock = 2'b10; bus.req_rw = 2'b00; bus.req_addr1 = 32'h200;
    #1 chk("rb_lat", bus.req_gnt, 2'b00);
    for (int w = 0; w < 4; w++) begin
      tick();
      bus.req_addr1 = 32'h200 + 32'(4 * w); bus.req_wdata1 = 32'hA5A5_0000 + 32'(w);
      bus.mem_ack = (w < 3);
      #1 chk("rb_gnt", bus.req_gnt, 2'b10);
      chk("rb_wdata", mem_data, 32'hA5A5_0000 + 32'(w));
      if (w < 3) chk("rb_ack", bus.req_ack, 2'b10);
    end
    #2 reset_n = 1'b0;
    #1 chk("rb_rst_gnt", bus.req_gnt, 2'b00);
    chk("rb_rst_ce", bus.mem_ce, 1'b0);
    chk("rb_rst_ack", bus.req_ack, 2'b00);
    tb_oe = 1'b1; tb_val = PROBE;
    #1 chk("rb_rst_data_z", mem_data, PROBE);
    bus.req_ce = 2'b11; bus.req_lock = 2'b00; bus.req_rw = 2'b11;
    bus.req_addr0 = 32'h300; bus.req_addr1 = 32'h304; tb_oe = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    #1 chk("rb_post_tie", bus.req_gnt, 2'b01);
    chk("rb_post_addr", bus.mem_addr, 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
